seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 53 +++++
 rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv | 66 ++++++
 rtl/seven_seg_scan_ctrl.sv | 84 ++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// LEADING_ZERO_BLANK_EN (optional macro) is consumed by seven_seg_scan_ctrl.
package seven_seg_scan_ctrl_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int unsigned BIN_W        = 10;
    localparam int unsigned BIN_MAX      = 999;
    localparam int unsigned SHIFT_CYCLES = 10;

    localparam logic [1:0] DIGIT_DARK = 2'd3;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble pre-shift correction: add 3 to any digit of 5 or more
    function automatic bcd_digit_t dd_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv
// Iterative double-dabble converter: 10-bit binary to three BCD digits,
// one shift per cycle (IDLE -> SHIFT x10 -> DONE x1).
module bin2bcd_seq
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output bcd_digit_t       bcd2,
    output bcd_digit_t       bcd1,
    output bcd_digit_t       bcd0
);

    conv_state_t      state, next_state;
    logic [3:0]       shift_cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [11:0]      bcd_sr;
    logic [11:0]      bcd_adj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (shift_cnt == 4'(SHIFT_CYCLES - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_comb begin
        bcd_adj = {dd_adjust(bcd_sr[11:8]), dd_adjust(bcd_sr[7:4]), dd_adjust(bcd_sr[3:0])};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
        end else if (state == IDLE && start) begin
            bin_sr    <= bin;
            bcd_sr    <= '0;
            shift_cnt <= '0;
        end else if (state == SHIFT) begin
            {bcd_sr, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
            shift_cnt        <= shift_cnt + 4'd1;
        end
    end

    assign bcd2 = bcd_sr[11:8];
    assign bcd1 = bcd_sr[7:4];
    assign bcd0 = bcd_sr[3:0];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Three-digit seven-segment scan controller with sequential BCD conversion.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] bin_in,
    input  logic       load,
    output logic       busy,
    output logic [1:0] digit_sel,
    output logic [6:0] seg
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [BIN_W-1:0] bin_clamped;
    logic             conv_done;
    bcd_digit_t       conv2, conv1, conv0;
    bcd_digit_t       disp2, disp1, disp0;
    logic [CNT_W-1:0] refresh_cnt;
    logic             wrap;
    logic             blank2, blank1;

    assign bin_clamped = (bin_in > BIN_W'(BIN_MAX)) ? BIN_W'(BIN_MAX) : bin_in;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (load),
        .bin     (bin_clamped),
        .busy    (busy),
        .done    (conv_done),
        .bcd2    (conv2),
        .bcd1    (conv1),
        .bcd0    (conv0)
    );

    // Display registers only ever change on the converter's single DONE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp2 <= '0;
            disp1 <= '0;
            disp0 <= '0;
        end else if (conv_done) begin
            disp2 <= conv2;
            disp1 <= conv1;
            disp0 <= conv0;
        end
    end

    assign wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_sel   <= DIGIT_DARK;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            if (wrap) digit_sel <= (digit_sel >= 2'd2) ? 2'd0 : digit_sel + 2'd1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank2 = (disp2 == 4'd0);
    assign blank1 = (disp2 == 4'd0) && (disp1 == 4'd0);
`else
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    always_comb begin
        seg = SEG_BLANK;
        case (digit_sel)
            2'd0:    seg = seg_decode(disp0);
            2'd1:    seg = blank1 ? SEG_BLANK : seg_decode(disp1);
            2'd2:    seg = blank2 ? SEG_BLANK : seg_decode(disp2);
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (REFRESH_DIV=4).
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seven_seg_scan_ctrl;

    localparam int DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZPAD = 7'b1111111;
`else
    localparam logic [6:0] ZPAD = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [9:0] bin_in = '0;
    logic       busy;
    logic [1:0] digit_sel;
    logic [6:0] seg;

    int tests = 0;
    int fails = 0;

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seven_seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bin_in    (bin_in),
        .load      (load),
        .busy      (busy),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // Model: cycles since reset release, remaining busy cycles, shown value
    int k_cyc = 0;
    int busy_left = 0;
    int disp_val = 0;
    int pending = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_cyc     <= 0;
            busy_left <= 0;
            disp_val  <= 0;
            pending   <= 0;
        end else begin
            k_cyc <= k_cyc + 1;
            if (busy_left == 0) begin
                if (load) begin
                    busy_left <= 11;
                    pending   <= (int'(bin_in) > 999) ? 999 : int'(bin_in);
                end
            end else begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) disp_val <= pending;
            end
        end
    end

    function automatic int exp_sel(input int k);
        if (k < DIV) return 3;
        return ((k / DIV) - 1) % 3;
    endfunction

    function automatic int exp_seg(input int sel, input int v);
        int d;
        if (sel == 3) return 'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (sel == 2 && v < 100) return 'h7F;
        if (sel == 1 && v < 10) return 'h7F;
`endif
        d = (sel == 0) ? v % 10 : (sel == 1) ? (v / 10) % 10 : v / 100;
        return int'(segtab[d]);
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("busy", int'(busy), (busy_left != 0) ? 1 : 0);
            check("digit_sel", int'(digit_sel), exp_sel(k_cyc));
            check("seg", int'(seg), exp_seg(exp_sel(k_cyc), disp_val));
        end
    end

    task automatic wait_sel(input int s, output int n);
        n = 0;
        while (int'(digit_sel) != s && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_sel_timeout", int'(digit_sel), s);
    endtask

    task automatic slot_check(input int s, input logic [6:0] req, input string name);
        int n;
        wait_sel(s, n);
        check(name, int'(seg), int'(req));
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        bin_in = 10'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_sel_lit", int'(digit_sel), 3);
        check("rst_seg_lit", int'(seg), 'h7F);
        check("rst_busy_lit", int'(busy), 0);

        wait_sel(0, n);
        wait_sel(1, n); check("step_0_1", n, DIV);
        wait_sel(2, n); check("step_1_2", n, DIV);
        wait_sel(0, n); check("step_2_0", n, DIV);

        do_load(123);
        busy_len(n);
        check("busy_len_123", n, 11);
        slot_check(0, 7'b0110000, "d123_s0");
        slot_check(1, 7'b0100100, "d123_s1");
        slot_check(2, 7'b1111001, "d123_s2");

        do_load(1023);
        busy_len(n);
        slot_check(0, 7'b0010000, "clamp_s0");
        slot_check(1, 7'b0010000, "clamp_s1");
        slot_check(2, 7'b0010000, "clamp_s2");

        do_load(5);
        repeat (3) @(negedge clk);
        bin_in = 10'd77; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        check("done_busy_lit", int'(busy), 1);
        bin_in = 10'd77; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("after_done_busy", int'(busy), 0);
        slot_check(0, 7'b0010010, "d5_s0");
        slot_check(1, ZPAD, "d5_s1");
        slot_check(2, ZPAD, "d5_s2");

        do_load(7);
        busy_len(n);
        slot_check(0, 7'b1111000, "d7_s0");
        slot_check(1, ZPAD, "d7_s1");
        slot_check(2, ZPAD, "d7_s2");

        do_load(456);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_sel", int'(digit_sel), 3);
        check("midrst_seg", int'(seg), 'h7F);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        slot_check(0, 7'b1000000, "rst_s0");
        slot_check(1, ZPAD, "rst_s1");
        slot_check(2, ZPAD, "rst_s2");
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
